video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 33 +++
 rtl/video_timing_gen_axis_phase_counter.sv | 57 +++++
 rtl/video_timing_gen.sv | 130 +++++++++++++
 tb/tb_video_timing_gen.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator.
package video_timing_pkg;

  // Output widths: linear position covers up to 2^21 pixels, each axis up to 1024.
  localparam int POS_W    = 21;
  localparam int AXIS_W   = 10;
  localparam int AXIS_MAX = 1 << AXIS_W;
  localparam int POS_MAX  = 1 << POS_W;

  // Phase of one raster axis, in the order it occurs within a line/frame.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_e;

  // Timing of one axis, in pixels (horizontal) or lines (vertical).
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  // 640x480@60, 800x525 total at 25.175 MHz.
  localparam axis_timing_t MODE_640X480_H  = '{active: 640,  fp: 16,  sync: 96, bp: 48};
  localparam axis_timing_t MODE_640X480_V  = '{active: 480,  fp: 10,  sync: 2,  bp: 33};
  // 1280x720@60, 1650x750 total at 74.25 MHz.
  localparam axis_timing_t MODE_1280X720_H = '{active: 1280, fp: 110, sync: 40, bp: 220};
  localparam axis_timing_t MODE_1280X720_V = '{active: 720,  fp: 5,   sync: 5,  bp: 20};

endpackage

// File: rtl/video_timing_gen_axis_phase_counter.sv
// Wrapping counter for one raster axis with carry-out and phase decode.
// The carry-out is qualified by the enable so it can directly advance the
// next (slower) axis.
module axis_phase_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int WIDTH  = AXIS_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output phase_e           o_phase
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Phase boundaries held one bit wider so a boundary equal to 2^WIDTH still fits.
  localparam logic [WIDTH:0]   FP_START   = (WIDTH+1)'(ACTIVE);
  localparam logic [WIDTH:0]   SYNC_START = (WIDTH+1)'(ACTIVE + FP);
  localparam logic [WIDTH:0]   BP_START   = (WIDTH+1)'(ACTIVE + FP + SYNC);
  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_count_ext;

  // Count enabled edges, wrapping to 0 after the last position of the axis.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  // Decode the phase the current count falls in.
  always_comb begin
    w_count_ext = {1'b0, r_count};
    o_phase     = PH_BP;
    if (w_count_ext < FP_START) begin
      o_phase = PH_ACTIVE;
    end else if (w_count_ext < SYNC_START) begin
      o_phase = PH_FP;
    end else if (w_count_ext < BP_START) begin
      o_phase = PH_SYNC;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = i_en && (r_count == LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered hsync/vsync/blank, linear position,
// axis counts and line/frame start pulses, all aligned to the same edge.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = MODE_640X480_H.active,
  parameter int   H_FP       = MODE_640X480_H.fp,
  parameter int   H_SYNC     = MODE_640X480_H.sync,
  parameter int   H_BP       = MODE_640X480_H.bp,
  parameter int   V_ACTIVE   = MODE_640X480_V.active,
  parameter int   V_FP       = MODE_640X480_V.fp,
  parameter int   V_SYNC     = MODE_640X480_V.sync,
  parameter int   V_BP       = MODE_640X480_V.bp,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_blank,
  output logic [POS_W-1:0]  o_pixel_pos,
  output logic [AXIS_W-1:0] o_x,
  output logic [AXIS_W-1:0] o_y,
  output logic              o_line_start,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject rasters that do not fit the output widths.
  if (H_TOTAL > AXIS_MAX || V_TOTAL > AXIS_MAX || H_TOTAL * V_TOTAL > POS_MAX) begin : g_bad_timing
    $error("video_timing_gen: raster %0dx%0d exceeds output widths", H_TOTAL, V_TOTAL);
  end

  logic [AXIS_W-1:0] w_h_count;
  logic [AXIS_W-1:0] w_v_count;
  logic              w_h_wrap;
  logic              w_v_wrap;
  phase_e            w_h_phase;
  phase_e            w_v_phase;

  logic [POS_W-1:0]  r_pos;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_blank;
  logic [POS_W-1:0]  r_pixel_pos;
  logic [AXIS_W-1:0] r_x;
  logic [AXIS_W-1:0] r_y;
  logic              r_line_start;
  logic              r_frame_start;

  axis_phase_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .WIDTH  (AXIS_W)
  ) u_h_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .o_count (w_h_count),
    .o_wrap  (w_h_wrap),
    .o_phase (w_h_phase)
  );

  // The vertical axis advances once per line, on the horizontal carry-out.
  axis_phase_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .WIDTH  (AXIS_W)
  ) u_v_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_h_wrap),
    .o_count (w_v_count),
    .o_wrap  (w_v_wrap),
    .o_phase (w_v_phase)
  );

  // Linear position tracks v*H_TOTAL+h incrementally; it wraps with the frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos <= '0;
    end else if (i_en) begin
      r_pos <= w_v_wrap ? '0 : r_pos + 1'b1;
    end
  end

  // Register the decode of the pre-increment counters; pulses clear on idle edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_blank       <= 1'b1;
      r_pixel_pos   <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (i_en) begin
      r_hsync       <= (w_h_phase == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= (w_v_phase == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
      r_blank       <= !((w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE));
      r_pixel_pos   <= r_pos;
      r_x           <= w_h_count;
      r_y           <= w_v_count;
      r_line_start  <= (w_h_count == '0);
      r_frame_start <= (w_h_count == '0) && (w_v_count == '0);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_blank       = r_blank;
  assign o_pixel_pos   = r_pixel_pos;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a default-mode instance and a
// small-mode instance (8x6 total) so full-frame behaviour fits a short run.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic        ls;
    logic        fs;
    logic [20:0] pos;
    logic [9:0]  x;
    logic [9:0]  y;
  } obs_t;

  logic clk;
  logic rst_d, en_d, rst_s, en_s;

  logic        hs_d, vs_d, bl_d, ls_d, fs_d;
  logic [20:0] pos_d;
  logic [9:0]  x_d, y_d;
  logic        hs_s, vs_s, bl_s, ls_s, fs_s;
  logic [20:0] pos_s;
  logic [9:0]  x_s, y_s;

  int total = 0;
  int bad   = 0;
  int n_d   = 0;
  int n_s   = 0;
  obs_t q_d[$];
  obs_t q_s[$];
  obs_t last_d;

  video_timing_gen dut (
    .i_clk(clk), .i_rst(rst_d), .i_en(en_d),
    .o_hsync(hs_d), .o_vsync(vs_d), .o_blank(bl_d), .o_pixel_pos(pos_d),
    .o_x(x_d), .o_y(y_d), .o_line_start(ls_d), .o_frame_start(fs_d)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_en(en_s),
    .o_hsync(hs_s), .o_vsync(vs_s), .o_blank(bl_s), .o_pixel_pos(pos_s),
    .o_x(x_s), .o_y(y_s), .o_line_start(ls_s), .o_frame_start(fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the n-th enabled edge after reset, computed from n directly.
  function automatic obs_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp, input int n);
    obs_t o;
    int ht, vt, x, y;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    x = n % ht;
    y = (n / ht) % vt;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.pos = 21'(n % (ht * vt));
    o.hs  = (x >= ha + hf && x < ha + hf + hsw) ? hp : ~hp;
    o.vs  = (y >= va + vf && y < va + vf + vsw) ? vp : ~vp;
    o.bl  = !(x < ha && y < va);
    o.ls  = (x == 0);
    o.fs  = (x == 0 && y == 0);
    return o;
  endfunction

  function automatic obs_t exp_d(input int n);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, n);
  endfunction

  function automatic obs_t exp_s(input int n);
    return model(4, 1, 1, 2, 3, 1, 1, 1, 1'b1, 1'b0, n);
  endfunction

  function automatic obs_t sample_d();
    obs_t o;
    o.hs = hs_d; o.vs = vs_d; o.bl = bl_d; o.ls = ls_d; o.fs = fs_d;
    o.pos = pos_d; o.x = x_d; o.y = y_d;
    return o;
  endfunction

  function automatic obs_t sample_s();
    obs_t o;
    o.hs = hs_s; o.vs = vs_s; o.bl = bl_s; o.ls = ls_s; o.fs = fs_s;
    o.pos = pos_s; o.x = x_s; o.y = y_s;
    return o;
  endfunction

  task automatic test_reset();
    obs_t got, want;
    rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b0; en_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    want = '{hs: 1'b1, vs: 1'b1, bl: 1'b1, ls: 1'b0, fs: 1'b0, pos: 21'd0, x: 10'd0, y: 10'd0};
    got = sample_d();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_default: got=%h want=%h", got, want);
    end
    want.hs = 1'b0;
    got = sample_s();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_small: got=%h want=%h", got, want);
    end
    rst_d = 1'b0; rst_s = 1'b0;
    n_d = 0; n_s = 0;
    $display("reset checked, released");
  endtask

  task automatic test_first_edge();
    obs_t got, want;
    en_d = 1'b1;
    q_d.push_back(exp_d(n_d));
    n_d++;
    @(posedge clk);
    #1;
    got = sample_d();
    want = q_d.pop_front();
    last_d = want;
    total++;
    if (got !== want || got.fs !== 1'b1 || got.bl !== 1'b0) begin
      bad++;
      $display("FAIL first_edge: got=%h want=%h", got, want);
    end
    $display("first edge: x=%0d y=%0d fs=%0d blank=%0d", got.x, got.y, got.fs, got.bl);
  endtask

  task automatic test_line0();
    obs_t got, want, prev;
    int fall_x, rise_x, blank_x, ls_at;
    fall_x = -1; rise_x = -1; blank_x = -1; ls_at = -1;
    prev = sample_d();
    for (int i = 1; i < 1600; i++) begin
      q_d.push_back(exp_d(n_d));
      n_d++;
      @(posedge clk);
      #1;
      got = sample_d();
      want = q_d.pop_front();
      last_d = want;
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL line0_cycle%0d: got=%h want=%h", i, got, want);
      end
      if (prev.hs && !got.hs && fall_x < 0) fall_x = int'(got.x);
      if (!prev.hs && got.hs && rise_x < 0) rise_x = int'(got.x);
      if (!prev.bl && got.bl && blank_x < 0) blank_x = int'(got.x);
      if (got.ls && ls_at < 0) ls_at = i;
      prev = got;
    end
    total++;
    if (fall_x != 656) begin
      bad++;
      $display("FAIL hsync_fall: got x=%0d want x=656", fall_x);
    end
    total++;
    if (rise_x != 752) begin
      bad++;
      $display("FAIL hsync_rise: got x=%0d want x=752", rise_x);
    end
    total++;
    if (blank_x != 640) begin
      bad++;
      $display("FAIL blank_rise: got x=%0d want x=640", blank_x);
    end
    total++;
    if (ls_at != 800) begin
      bad++;
      $display("FAIL line_start_period: got %0d want 800", ls_at);
    end
    $display("line0: hsync fall=%0d rise=%0d blank rise=%0d next line_start=%0d",
             fall_x, rise_x, blank_x, ls_at);
  endtask

  task automatic test_enable_random();
    obs_t got, want, prev, held;
    int spans, idle;
    spans = 0; idle = 0;
    prev = sample_d();
    for (int i = 0; i < 2000; i++) begin
      en_d = ($urandom_range(99, 0) >= 30);
      if (en_d) begin
        q_d.push_back(exp_d(n_d));
        n_d++;
      end else begin
        held = last_d;
        held.ls = 1'b0;
        held.fs = 1'b0;
        q_d.push_back(held);
        idle++;
      end
      @(posedge clk);
      #1;
      got = sample_d();
      want = q_d.pop_front();
      if (en_d) last_d = want;
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL enable_cycle%0d(en=%0d): got=%h want=%h", i, en_d, got, want);
      end
      if ((got.ls && prev.ls) || (got.fs && prev.fs)) spans++;
      prev = got;
    end
    en_d = 1'b0;
    total++;
    if (spans != 0) begin
      bad++;
      $display("FAIL pulse_span: got %0d spans want 0", spans);
    end
    $display("random enable: %0d idle cycles, %0d pulse spans", idle, spans);
  endtask

  task automatic test_small_frame();
    obs_t got, want, prev;
    int wrap_prev, fs_first, fs_second, vs_low, hs_high, blank_bad, pos_bad;
    wrap_prev = -1; fs_first = -1; fs_second = -1;
    vs_low = 0; hs_high = 0; blank_bad = 0; pos_bad = 0;
    en_s = 1'b1;
    prev = sample_s();
    for (int i = 0; i < 100; i++) begin
      q_s.push_back(exp_s(n_s));
      n_s++;
      @(posedge clk);
      #1;
      got = sample_s();
      want = q_s.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL small_cycle%0d: got=%h want=%h", i, got, want);
      end
      if (i > 0 && got.pos == 21'd0 && wrap_prev < 0) wrap_prev = int'(prev.pos);
      if (got.fs) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (i < 96) begin
        if (!got.vs) vs_low++;
        if (got.hs) hs_high++;
      end
      if (got.y >= 10'd3 && !got.bl) blank_bad++;
      if (int'(got.pos) != int'(got.y) * 8 + int'(got.x)) pos_bad++;
      prev = got;
    end
    total++;
    if (wrap_prev != 47) begin
      bad++;
      $display("FAIL small_wrap: got pos %0d before 0, want 47", wrap_prev);
    end
    total++;
    if (fs_second - fs_first != 48 || fs_first != 0) begin
      bad++;
      $display("FAIL frame_period: got %0d..%0d want 0..48", fs_first, fs_second);
    end
    total++;
    if (vs_low != 16) begin
      bad++;
      $display("FAIL vsync_low_count: got %0d want 16", vs_low);
    end
    total++;
    if (hs_high != 12) begin
      bad++;
      $display("FAIL hsync_active_count: got %0d want 12", hs_high);
    end
    total++;
    if (blank_bad != 0 || pos_bad != 0) begin
      bad++;
      $display("FAIL small_consistency: blank_bad=%0d pos_bad=%0d want 0/0", blank_bad, pos_bad);
    end
    $display("small frame: wrap after %0d, frame period %0d, vsync low %0d",
             wrap_prev, fs_second - fs_first, vs_low);
  endtask

  task automatic test_mid_reset();
    obs_t got, want, prev, rst_want;
    bit found;
    int wrap_prev;
    found = 1'b0;
    wrap_prev = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      q_s.push_back(exp_s(n_s));
      n_s++;
      @(posedge clk);
      #1;
      got = sample_s();
      want = q_s.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL pre_reset_cycle%0d: got=%h want=%h", i, got, want);
      end
      if (got.x == 10'd5 && got.y == 10'd2) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reach_5_2: got not reached want (5,2)");
    end
    rst_want = '{hs: 1'b0, vs: 1'b1, bl: 1'b1, ls: 1'b0, fs: 1'b0, pos: 21'd0, x: 10'd0, y: 10'd0};
    #2 rst_s = 1'b1;
    #1;
    got = sample_s();
    total++;
    if (got !== rst_want) begin
      bad++;
      $display("FAIL async_reset: got=%h want=%h", got, rst_want);
    end
    @(posedge clk);
    #1;
    got = sample_s();
    total++;
    if (got !== rst_want) begin
      bad++;
      $display("FAIL reset_hold: got=%h want=%h", got, rst_want);
    end
    rst_s = 1'b0;
    q_s.delete();
    n_s = 0;
    prev = got;
    for (int i = 0; i < 50; i++) begin
      q_s.push_back(exp_s(n_s));
      n_s++;
      @(posedge clk);
      #1;
      got = sample_s();
      want = q_s.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL restart_cycle%0d: got=%h want=%h", i, got, want);
      end
      if (i > 0 && got.pos == 21'd0 && wrap_prev < 0) wrap_prev = int'(prev.pos);
      prev = got;
    end
    en_s = 1'b0;
    total++;
    if (wrap_prev != 47) begin
      bad++;
      $display("FAIL restart_wrap: got pos %0d before 0, want 47", wrap_prev);
    end
    $display("mid-line reset at (5,2): restart wrap after %0d", wrap_prev);
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_line0();
    test_enable_random();
    test_small_frame();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
